// File: rtl/gshare_pattern_table.sv
// ----------------------------------------------------------------------------
// gshare_pattern_table
//
// Pattern history table of 2-bit saturating counters for a gshare branch
// predictor. A request hashes the branch history with the word-aligned PC
// (idx = pred_bhr ^ pred_pc[M+1:2]) and returns the counter MSB one cycle
// later. Resolved outcomes train the counters through a separate update port.
// After reset a sweep writes INIT_CTR into every entry; no request is taken
// until the sweep is done.
//
// Optional build macro:
//   PHT_BYPASS_EN - a request and an update to the same index in the same
//                   cycle forward the post-update counter MSB to the result.
//                   When undefined, the request sees the pre-update value.
//
// Ports:
//   clk            in   rising-edge clock
//   reset_n        in   asynchronous active-low reset
//   pred_valid     in   prediction request
//   pred_pc        in   branch PC (bits [1:0] ignored)
//   pred_bhr       in   current branch history
//   pred_ready     out  table accepts a request this cycle
//   pred_out_valid out  one-cycle pulse, result valid
//   pred_taken     out  predicted direction (1 = taken), held between results
//   pred_index     out  table index used, held between results
//   upd_valid      in   resolved-branch update (dropped during init)
//   upd_index      in   index previously returned on pred_index
//   upd_taken      in   actual outcome (1 = taken)
//   init_done      out  table initialisation complete
// ----------------------------------------------------------------------------
module gshare_pattern_table #(
    parameter int         M        = 4,
    parameter int         PC_W     = 32,
    parameter logic [1:0] INIT_CTR = 2'b01
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            pred_valid,
    input  logic [PC_W-1:0] pred_pc,
    input  logic [M-1:0]    pred_bhr,
    output logic            pred_ready,
    output logic            pred_out_valid,
    output logic            pred_taken,
    output logic [M-1:0]    pred_index,
    input  logic            upd_valid,
    input  logic [M-1:0]    upd_index,
    input  logic            upd_taken,
    output logic            init_done
);

    localparam int DEPTH = 1 << M;

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [0:0]   state_q, state_d;
    logic [M-1:0] ptr_q, ptr_d;

    logic [1:0]   table_q [DEPTH];

    logic         out_valid_q;
    logic         out_taken_q;
    logic [M-1:0] out_index_q;

    logic [M-1:0] idx;
    logic         accept;
    logic         upd_fire;
    logic [1:0]   upd_cur;
    logic [1:0]   upd_next;
    logic         rd_taken;

    // Only PC bits [M+1:2] feed the hash; the rest are intentionally unused.
    generate
        if (PC_W > M + 2) begin : g_pc_hi
            logic unused_pc;
            assign unused_pc = ^{pred_pc[PC_W-1:M+2], pred_pc[1:0]};
        end else begin : g_pc_lo
            logic unused_pc;
            assign unused_pc = ^pred_pc[1:0];
        end
    endgenerate

    assign idx        = pred_bhr ^ pred_pc[M+1:2];
    assign pred_ready = (state_q == ST_READY);
    assign init_done  = (state_q == ST_READY);
    assign accept     = pred_valid && pred_ready;
    assign upd_fire   = upd_valid && (state_q == ST_READY);
    assign upd_cur    = table_q[upd_index];

    // Saturating +/-1 for the counter being trained.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (which would infer a latch).
        upd_next = upd_cur;
        if (upd_taken) begin
            if (upd_cur != 2'b11) upd_next = upd_cur + 2'd1;
        end else begin
            if (upd_cur != 2'b00) upd_next = upd_cur - 2'd1;
        end
    end

    // Prediction read, optionally forwarding a same-cycle update.
    always_comb begin
        rd_taken = table_q[idx][1];
`ifdef PHT_BYPASS_EN
        if (upd_fire && (upd_index == idx)) rd_taken = upd_next[1];
`endif
    end

    // Init sweep: one entry per cycle, READY after the last entry is written.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (state_q == ST_INIT) begin
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == M'(DEPTH - 1)) state_d = ST_READY;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset_n) begin
            state_q <= ST_INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // NOTE: the counter array has no reset; the init sweep overwrites every entry, which keeps it mappable to RAM.
    always_ff @(posedge clk) begin
        if (state_q == ST_INIT) begin
            table_q[ptr_q] <= INIT_CTR;
        end else if (upd_valid) begin
            table_q[upd_index] <= upd_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_taken_q <= 1'b0;
            out_index_q <= '0;
        end else begin
            out_valid_q <= accept;
            if (accept) begin
                out_taken_q <= rd_taken;
                out_index_q <= idx;
            end
        end
    end

    assign pred_out_valid = out_valid_q;
    assign pred_taken     = out_taken_q;
    assign pred_index     = out_index_q;

endmodule

// File: tb/tb_gshare_pattern_table.sv
// ----------------------------------------------------------------------------
// tb_gshare_pattern_table
//
// Directed bench for gshare_pattern_table (M=4, PC_W=32). Covers the init
// sweep length, index hash, saturation at both ends, same-cycle conflicts
// (expectation follows PHT_BYPASS_EN), independent predict/update and
// asynchronous reset in the middle of operation.
// ----------------------------------------------------------------------------
module tb_gshare_pattern_table;

    localparam int M    = 4;
    localparam int PC_W = 32;

`ifdef PHT_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset_n;
    logic            pred_valid;
    logic [PC_W-1:0] pred_pc;
    logic [M-1:0]    pred_bhr;
    logic            pred_ready;
    logic            pred_out_valid;
    logic            pred_taken;
    logic [M-1:0]    pred_index;
    logic            upd_valid;
    logic [M-1:0]    upd_index;
    logic            upd_taken;
    logic            init_done;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    gshare_pattern_table #(.M(M), .PC_W(PC_W), .INIT_CTR(2'b01)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .pred_valid     (pred_valid),
        .pred_pc        (pred_pc),
        .pred_bhr       (pred_bhr),
        .pred_ready     (pred_ready),
        .pred_out_valid (pred_out_valid),
        .pred_taken     (pred_taken),
        .pred_index     (pred_index),
        .upd_valid      (upd_valid),
        .upd_index      (upd_index),
        .upd_taken      (upd_taken),
        .init_done      (init_done)
    );

    typedef struct {
        string      name;
        logic       pv;
        logic [3:0] bhr;
        logic [31:0] pc;
        logic       uv;
        logic [3:0] uidx;
        logic       ut;
        logic       ev;
        logic       et;
        logic [3:0] eidx;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic pv, logic [3:0] bhr, logic [31:0] pc,
                                logic uv, logic [3:0] uidx, logic ut,
                                logic ev, logic et, logic [3:0] eidx);
        vec_t v;
        v.name = name; v.pv = pv; v.bhr = bhr; v.pc = pc;
        v.uv = uv; v.uidx = uidx; v.ut = ut;
        v.ev = ev; v.et = et; v.eidx = eidx;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Count cycles until pred_ready rises, checking INIT-time outputs.
    task automatic wait_init(string tag);
        int cnt = 0;
        while (!pred_ready && cnt < 40) begin
            check({tag, "_init_done_low"}, 32'(init_done), 32'd0);
            check({tag, "_no_result_in_init"}, 32'(pred_out_valid), 32'd0);
            step();
            cnt++;
        end
        check({tag, "_init_cycles"}, 32'(cnt), 32'd16);
        check({tag, "_init_done"}, 32'(init_done), 32'd1);
    endtask

    initial begin
        reset_n    = 1'b0;
        pred_valid = 1'b0;
        pred_pc    = '0;
        pred_bhr   = '0;
        upd_valid  = 1'b0;
        upd_index  = '0;
        upd_taken  = 1'b0;

        // Vector table: applied one per cycle after init; results checked
        // right after the edge that consumed the vector.
        vecs.push_back(mk("hash_1010_x_0101",   1, 4'b1010, 32'h14, 0, 0, 0, 1, 0, 4'hF));
        vecs.push_back(mk("upd3_T_01to10",      0, 0, 32'h0,        1, 3, 1, 0, 0, 4'hF));
        vecs.push_back(mk("upd3_T_10to11",      0, 0, 32'h0,        1, 3, 1, 0, 0, 4'hF));
        vecs.push_back(mk("upd3_T_sat11",       0, 0, 32'h0,        1, 3, 1, 0, 0, 4'hF));
        vecs.push_back(mk("pred3_after_sat",    1, 0, 32'h0C,       0, 0, 0, 1, 1, 4'h3));
        vecs.push_back(mk("upd3_NT_11to10",     0, 0, 32'h0,        1, 3, 0, 0, 1, 4'h3));
        vecs.push_back(mk("upd3_NT_10to01",     0, 0, 32'h0,        1, 3, 0, 0, 1, 4'h3));
        vecs.push_back(mk("pred3_after_dec",    1, 0, 32'h0C,       0, 0, 0, 1, 0, 4'h3));
        vecs.push_back(mk("upd0_NT_01to00",     0, 0, 32'h0,        1, 0, 0, 0, 0, 4'h3));
        vecs.push_back(mk("upd0_NT_sat00",      0, 0, 32'h0,        1, 0, 0, 0, 0, 4'h3));
        vecs.push_back(mk("upd0_T_00to01",      0, 0, 32'h0,        1, 0, 1, 0, 0, 4'h3));
        vecs.push_back(mk("pred0_after_sat00",  1, 0, 32'h00,       0, 0, 0, 1, 0, 4'h0));
        vecs.push_back(mk("hash_0011_x_0011",   1, 4'b0011, 32'h0C, 0, 0, 0, 1, 0, 4'h0));
        vecs.push_back(mk("conflict_idx5",      1, 0, 32'h14,       1, 5, 1, 1, BYP, 4'h5));
        vecs.push_back(mk("pred5_after_upd",    1, 0, 32'h14,       0, 0, 0, 1, 1, 4'h5));
        vecs.push_back(mk("pred3_upd6_indep",   1, 0, 32'h0C,       1, 6, 1, 1, 0, 4'h3));
        vecs.push_back(mk("pred6_after_upd",    1, 0, 32'h18,       0, 0, 0, 1, 1, 4'h6));
        vecs.push_back(mk("hash_1111_x_0101",   1, 4'b1111, 32'h14, 0, 0, 0, 1, 0, 4'hA));
        vecs.push_back(mk("idle_hold",          0, 0, 32'h0,        0, 0, 0, 0, 0, 4'hA));

        // Reset state.
        #12;
        check("rst_pred_ready", 32'(pred_ready), 32'd0);
        check("rst_out_valid", 32'(pred_out_valid), 32'd0);
        check("rst_taken", 32'(pred_taken), 32'd0);
        check("rst_index", 32'(pred_index), 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);

        // Release reset with a request held: 16 INIT cycles, then accepted.
        @(negedge clk);
        reset_n    = 1'b1;
        pred_valid = 1'b1;
        pred_bhr   = 4'b0000;
        pred_pc    = 32'h1C;
        wait_init("boot");
        check("boot_no_result_yet", 32'(pred_out_valid), 32'd0);
        step();
        check("boot_first_valid", 32'(pred_out_valid), 32'd1);
        check("boot_first_taken", 32'(pred_taken), 32'd0);
        check("boot_first_index", 32'(pred_index), 32'd7);
        pred_valid = 1'b0;
        step();
        check("boot_pulse_ends", 32'(pred_out_valid), 32'd0);

        // Table-driven section.
        for (int i = 0; i < vecs.size(); i++) begin
            pred_valid = vecs[i].pv;
            pred_bhr   = vecs[i].bhr;
            pred_pc    = vecs[i].pc;
            upd_valid  = vecs[i].uv;
            upd_index  = vecs[i].uidx;
            upd_taken  = vecs[i].ut;
            step();
            check({vecs[i].name, "_valid"}, 32'(pred_out_valid), 32'(vecs[i].ev));
            check({vecs[i].name, "_taken"}, 32'(pred_taken), 32'(vecs[i].et));
            check({vecs[i].name, "_index"}, 32'(pred_index), 32'(vecs[i].eidx));
        end
        pred_valid = 1'b0;
        upd_valid  = 1'b0;

        // Mid-operation reset: five updates, then a request in flight.
        for (int i = 0; i < 5; i++) begin
            upd_valid = 1'b1;
            upd_index = (i < 2) ? 4'd2 : ((i < 4) ? 4'd9 : 4'd12);
            upd_taken = (i < 4);
            step();
        end
        upd_valid  = 1'b0;
        pred_valid = 1'b1;
        pred_bhr   = 4'b0000;
        pred_pc    = 32'h08;
        step();
        check("inflight_valid", 32'(pred_out_valid), 32'd1);
        check("inflight_taken", 32'(pred_taken), 32'd1);
        pred_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(pred_out_valid), 32'd0);
        check("async_rst_taken", 32'(pred_taken), 32'd0);
        check("async_rst_index", 32'(pred_index), 32'd0);
        check("async_rst_ready", 32'(pred_ready), 32'd0);
        check("async_rst_init_done", 32'(init_done), 32'd0);

        // Updates during the new sweep must be dropped.
        @(negedge clk);
        reset_n   = 1'b1;
        upd_valid = 1'b1;
        upd_index = 4'd0;
        upd_taken = 1'b1;
        wait_init("reinit");
        upd_valid = 1'b0;

        // Every index predicts not-taken, back to back.
        for (int i = 0; i < 16; i++) begin
            pred_valid = 1'b1;
            pred_bhr   = 4'b0000;
            pred_pc    = 32'(i) << 2;
            step();
            check($sformatf("reinit_idx%0d_valid", i), 32'(pred_out_valid), 32'd1);
            check($sformatf("reinit_idx%0d_taken", i), 32'(pred_taken), 32'd0);
            check($sformatf("reinit_idx%0d_index", i), 32'(pred_index), 32'(i));
        end
        pred_valid = 1'b0;
        step();
        check("final_idle_valid", 32'(pred_out_valid), 32'd0);
        check("final_hold_index", 32'(pred_index), 32'd15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/gshare_pattern_table.md
Name: gshare_pattern_table

Overview:
- Pattern history table (PHT) of 2-bit saturating counters, one stage downstream of the branch history register.
- Consumes the current M-bit history and the branch PC. Indexes the table with history XOR PC bits, and returns a registered taken/not-taken prediction.
- Accepts resolved outcomes on a separate update port to train the counters.
- After reset, a sweep FSM initialises the table before any prediction is accepted.

Parameters:
- M, 4, history width; table depth is 2^M entries.
- PC_W, 32, PC width; must satisfy PC_W >= M+2.
- INIT_CTR, 2'b01, counter value written to every entry during init (weakly not-taken).

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- pred_valid  in  1  prediction request.
- pred_pc  in  PC_W  branch PC.
- pred_bhr  in  M  current branch history.
- pred_ready  out  1  table can accept a request this cycle.
- pred_out_valid  out  1  prediction result valid (one-cycle pulse).
- pred_taken  out  1  predicted direction (1 = taken).
- pred_index  out  M  table index used; the pipeline carries it to the update port.
- upd_valid  in  1  resolved-branch update.
- upd_index  in  M  index returned earlier on pred_index.
- upd_taken  in  1  actual outcome (1 = taken).
- init_done  out  1  high once table initialisation is complete.

Behaviour:
- Reset (reset_n low, asynchronous):
  - pred_ready=0, pred_out_valid=0, pred_taken=0, pred_index=0, init_done=0.
  - FSM forced to INIT, init pointer = 0.
  - Table storage has no reset; the init sweep overwrites it.
  - Reset asserted mid-sweep or mid-operation: any in-flight result is discarded and the sweep restarts from 0.
- FSM states: INIT, READY.
  - INIT: writes INIT_CTR to entry ptr each cycle, ptr increments. On the cycle ptr = 2^M-1 is written, go to READY. INIT lasts exactly 2^M cycles after reset release.
  - READY: init_done=1 and pred_ready=1. Stays in READY until the next reset.
- Indexing: idx = pred_bhr XOR pred_pc[M+1:2]. PC bits [1:0] are ignored (word-aligned).
- Prediction:
  - A request is accepted when pred_valid && pred_ready.
  - Latency is 1 cycle: the next cycle has pred_out_valid=1, pred_taken=table[idx][1], pred_index=idx.
  - Back-to-back requests are accepted every cycle.
  - With no accepted request, pred_out_valid=0 and pred_taken/pred_index hold their last values.
- Update:
  - upd_valid in READY: in the same cycle, table[upd_index] gets a saturating ±1. Taken increments, saturating at 2'b11. Not-taken decrements, saturating at 2'b00.
  - The new value is visible to reads from the next cycle.
  - upd_valid during INIT is ignored and dropped; no error flag.
- Simultaneous predict and update, same index, same cycle: the prediction reads the pre-update counter unless PHT_BYPASS_EN is defined.
- Simultaneous predict and update to different indices: both take effect with no interaction.
- Counter encoding: 00 strongly NT, 01 weakly NT, 10 weakly T, 11 strongly T.

Optional Feature:
- Macro: PHT_BYPASS_EN.
- Defined: when an accepted request and upd_valid hit the same index in the same cycle, the prediction uses the post-update counter's MSB (forwarded).
- Undefined: the prediction uses the stored, pre-update value.
- All other behaviour is identical in both builds.

Test Plan:
- Reset/init, M=4: release reset_n, hold pred_valid=1 -> pred_ready=0 and init_done=0 for exactly 16 cycles, then both 1. The first prediction for any index gives pred_taken=0 and pred_out_valid one cycle after acceptance.
- Index hash: pred_bhr=4'b1010, pred_pc=32'h0000_0014 -> pred_index=4'b1111 (1010 XOR 0101), one cycle after acceptance.
- Saturation at 11: three taken updates to index 3 -> counter 01→10→11→11. The prediction then gives pred_taken=1. Two not-taken updates then take it 11→10→01, and the prediction gives pred_taken=0.
- Saturation at 00: two not-taken updates to index 0 -> counter stays at 00. One taken update -> 01, pred_taken=0.
- Same-cycle conflict: index 5 at 01, predict index 5 plus upd_taken=1 to index 5 in the same cycle -> pred_taken=0 without PHT_BYPASS_EN, pred_taken=1 with it. A following prediction of index 5 gives 1 in both builds.
- Reset mid-operation: assert reset_n low after 5 updates and with a request in flight -> pred_out_valid=0 immediately (asynchronous). After release, 16 INIT cycles run and every index predicts 0. Updates issued during INIT have no effect.
